usr_cmd_sequencer: RTL and testbench



---
 rtl/usr_seq_pkg.sv | 21 ++
 rtl/usr_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_usr_cmd_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/usr_seq_pkg.sv
// Shared types for the universal-shift-register command sequencer.
// op_e doubles as the {s1,s0} mode encoding of the downstream register.
package usr_seq_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefCntW  = 3;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer driving s1/s0, I_par and serial inputs of a universal shift register.
// Accepts one command per valid/ready handshake and pulses done when the register holds the result.
module usr_cmd_sequencer
  import usr_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  output logic             s1_o,
  output logic             s0_o,
  output logic [WIDTH-1:0] i_par_o,
  output logic             msb_in_o,
  output logic             lsb_in_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] i_par_q, i_par_d;
  logic             msb_q, msb_d;
  logic             lsb_q, lsb_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             drv_en;
  op_e              drv_op;
  logic [WIDTH-1:0] drv_data;
  logic [CNT_W-1:0] drv_k;
  logic [IdxW-1:0]  drv_idx;
  logic [CNT_W-1:0] n_new;
  logic [CNT_W-1:0] k_inc;

  assign k_inc = k_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    n_d      = n_q;
    k_d      = k_q;
    sel_d    = OP_NOP;
    i_par_d  = '0;
    msb_d    = 1'b0;
    lsb_d    = 1'b0;
    done_d   = 1'b0;
    n_new    = '0;
    drv_en   = 1'b0;
    drv_op   = op_q;
    drv_data = data_q;
    drv_k    = k_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && ready_q) begin
          op_d   = op_e'(cmd_op_i);
          data_d = cmd_data_i;
          k_d    = '0;
          case (op_e'(cmd_op_i))
            OP_LOAD:        n_new = CNT_W'(1);
            OP_SHR, OP_SHL: n_new = cmd_count_i;
            default:        n_new = '0;
          endcase
          n_d = n_new;
          // Zero-length commands skip RUN but still complete with a done pulse.
          if (n_new == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = RUN;
            drv_en   = 1'b1;
            drv_op   = op_e'(cmd_op_i);
            drv_data = cmd_data_i;
            drv_k    = '0;
          end
        end
      end
      RUN: begin
        if (k_inc == n_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          k_d    = k_inc;
          drv_en = 1'b1;
          drv_k  = k_inc;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Serial bit source wraps over the data word for counts beyond WIDTH.
    drv_idx = IdxW'(32'(drv_k) % WIDTH);
    if (drv_en) begin
      sel_d = drv_op;
      case (drv_op)
        OP_LOAD: i_par_d = drv_data;
        OP_SHR:  msb_d   = drv_data[drv_idx];
        OP_SHL:  lsb_d   = drv_data[drv_idx];
        default: ;
      endcase
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      sel_q   <= 2'b00;
      i_par_q <= '0;
      msb_q   <= 1'b0;
      lsb_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      n_q     <= n_d;
      k_q     <= k_d;
      sel_q   <= sel_d;
      i_par_q <= i_par_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign s1_o        = sel_q[1];
  assign s0_o        = sel_q[0];
  assign i_par_o     = i_par_q;
  assign msb_in_o    = msb_q;
  assign lsb_in_o    = lsb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed bench for usr_cmd_sequencer driving a behavioural 4-bit universal shift register.
module tb_usr_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'b0000;
  logic [2:0] cmd_count = 3'd0;
  logic       s1, s0, msb_in, lsb_in, busy, done;
  logic [3:0] i_par;
  logic [3:0] a_par;

  int compared = 0;
  int mismatched = 0;

  usr_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .cmd_count_i (cmd_count),
    .s1_o        (s1),
    .s0_o        (s0),
    .i_par_o     (i_par),
    .msb_in_o    (msb_in),
    .lsb_in_o    (lsb_in),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register, active-low reset driven by ~reset.
  wire rst_n = ~reset;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_par <= 4'b0000;
    else begin
      case ({s1, s0})
        2'b01:   a_par <= {msb_in, a_par[3:1]};
        2'b10:   a_par <= {a_par[2:0], lsb_in};
        2'b11:   a_par <= i_par;
        default: a_par <= a_par;
      endcase
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] cnt;
    int         n;
    logic [7:0] ser;
    logic [3:0] a_exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
    wait_ready();
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_count = cnt + 3'd3;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    send(v.op, v.data, v.cnt);
    for (int k = 0; k < v.n; k++) begin
      chk($sformatf("v%0d k%0d sel", idx, k), {30'd0, s1, s0}, {30'd0, v.op});
      chk($sformatf("v%0d k%0d i_par", idx, k), {28'd0, i_par},
          (v.op == 2'b11) ? {28'd0, v.data} : 32'd0);
      chk($sformatf("v%0d k%0d msb", idx, k), {31'd0, msb_in},
          (v.op == 2'b01) ? {31'd0, v.ser[k]} : 32'd0);
      chk($sformatf("v%0d k%0d lsb", idx, k), {31'd0, lsb_in},
          (v.op == 2'b10) ? {31'd0, v.ser[k]} : 32'd0);
      chk($sformatf("v%0d k%0d busy/ready/done", idx, k), {29'd0, busy, cmd_ready, done},
          32'b100);
      @(posedge clk);
      #1;
    end
    chk($sformatf("v%0d fin done/busy/ready", idx), {29'd0, done, busy, cmd_ready}, 32'b110);
    chk($sformatf("v%0d fin sel", idx), {30'd0, s1, s0}, 32'd0);
    chk($sformatf("v%0d fin serial/i_par", idx), {26'd0, msb_in, lsb_in, i_par}, 32'd0);
    chk($sformatf("v%0d a_par", idx), {28'd0, a_par}, {28'd0, v.a_exp});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d idle done/busy/ready", idx), {29'd0, done, busy, cmd_ready}, 32'b001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{op: 2'b11, data: 4'b1010, cnt: 3'd5, n: 1, ser: 8'h00, a_exp: 4'b1010};
    vecs[1] = '{op: 2'b01, data: 4'b0011, cnt: 3'd2, n: 2, ser: 8'b0000_0011, a_exp: 4'b1110};
    vecs[2] = '{op: 2'b11, data: 4'b0000, cnt: 3'd0, n: 1, ser: 8'h00, a_exp: 4'b0000};
    vecs[3] = '{op: 2'b10, data: 4'b0101, cnt: 3'd3, n: 3, ser: 8'b0000_0101, a_exp: 4'b0101};
    vecs[4] = '{op: 2'b01, data: 4'b1111, cnt: 3'd0, n: 0, ser: 8'h00, a_exp: 4'b0101};
    vecs[5] = '{op: 2'b00, data: 4'b1111, cnt: 3'd7, n: 0, ser: 8'h00, a_exp: 4'b0101};
    vecs[6] = '{op: 2'b11, data: 4'b0000, cnt: 3'd1, n: 1, ser: 8'h00, a_exp: 4'b0000};
    vecs[7] = '{op: 2'b10, data: 4'b0001, cnt: 3'd7, n: 7, ser: 8'b0001_0001, a_exp: 4'b0100};
    vecs[8] = '{op: 2'b01, data: 4'b0110, cnt: 3'd5, n: 5, ser: 8'b0000_0110, a_exp: 4'b0011};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst sel", {30'd0, s1, s0}, 32'd0);
    chk("rst i_par/serial", {26'd0, i_par, msb_in, lsb_in}, 32'd0);
    chk("rst done/busy/ready", {29'd0, done, busy, cmd_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst ready", {31'd0, cmd_ready}, 32'd1);

    // Idle hold: an op on the bus without valid must not drive the register
    cmd_op   = 2'b11;
    cmd_data = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("idle hold sel", {30'd0, s1, s0}, 32'd0);
    chk("idle hold a_par", {28'd0, a_par}, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Handshake: valid held high with changing inputs
    wait_ready();
    cmd_op    = 2'b11;
    cmd_data  = 4'b0110;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("hs first sel", {30'd0, s1, s0}, 32'b11);
    chk("hs first i_par", {28'd0, i_par}, 32'b0110);
    chk("hs run ready", {31'd0, cmd_ready}, 32'd0);
    cmd_data = 4'b1001;
    @(posedge clk);
    #1;
    chk("hs fin done/ready", {30'd0, done, cmd_ready}, 32'b10);
    chk("hs fin a_par", {28'd0, a_par}, 32'b0110);
    @(posedge clk);
    #1;
    chk("hs idle ready/sel", {29'd0, cmd_ready, s1, s0}, 32'b100);
    @(posedge clk);
    #1;
    chk("hs second sel", {30'd0, s1, s0}, 32'b11);
    chk("hs second i_par", {28'd0, i_par}, 32'b1001);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("hs second done/a_par", {27'd0, done, a_par}, 32'b1_1001);
    @(posedge clk);
    #1;

    // Reset mid-RUN aborts the command without a done pulse
    send(2'b01, 4'b1111, 3'd5);
    chk("abort k0 msb", {31'd0, msb_in}, 32'd1);
    @(posedge clk);
    #1;
    chk("abort k1 sel", {30'd0, s1, s0}, 32'b01);
    reset = 1'b1;
    #1;
    chk("abort async sel", {30'd0, s1, s0}, 32'd0);
    chk("abort async out", {23'd0, msb_in, lsb_in, i_par, done, busy, cmd_ready}, 32'd0);
    chk("abort a_par", {28'd0, a_par}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("abort no done", {30'd0, done, busy}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    run_vec(9, '{op: 2'b11, data: 4'b1111, cnt: 3'd0, n: 1, ser: 8'h00, a_exp: 4'b1111});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
